psum_accum: RTL and testbench
=============================

# psum_accum

Output-side special-function stage of the systolic core. It drains column-aligned partial-sum vectors from the output FIFO and accumulates them across `kij_len` passes into an internal `num_inp`-entry psum store. It applies optional ReLU on the final pass and exposes the store to the host through a registered read port. It replaces the external psum memory path currently driven by the testbench.

## Interface

**Parameters**
- `col`, 8: lanes per vector.
- `psum_bw`, 16: bits per lane, signed two's complement.
- `num_inp`, 64: vectors per pass, which is also the number of store entries. Must be ≥2.
- `kij_len`, 9: passes per computation. Must be ≥1.
- `addr_bw`, 6: store address width. Must satisfy 2^addr_bw ≥ num_inp.

**Ports**
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low.
- `start`, input, 1: one-cycle pulse that begins a computation. Sampled only in IDLE or DONE.
- `relu`, input, 1: apply ReLU on the final pass. Sampled and latched at `start`.
- `o_valid`, input, 1: the output FIFO is non-empty.
- `ofifo_dout`, input, col*psum_bw: show-ahead FIFO head. Valid whenever `o_valid`=1.
- `ofifo_rd`, output, 1: pop strobe, combinational.
- `psum_rd`, input, 1: host read request.
- `psum_addr`, input, addr_bw: host read address.
- `psum_mem_dout`, output, col*psum_bw: registered host read data. Lane k is at bits [(k+1)*psum_bw-1 : k*psum_bw].
- `iter_done`, output, 1: one-cycle pulse when the last write of each pass commits.
- `compute_done`, output, 1: level signal. High from final commit until the next accepted `start` or reset.
- `busy`, output, 1: high in RUN and DRAIN.

## Operation

**State machine: IDLE, RUN, DRAIN, DONE**
- IDLE/DONE → RUN on `start`.
  - Clear `addr_cnt` and `pass_cnt`.
  - Latch `relu`.
  - Drop `compute_done`.
- RUN:
  - `ofifo_rd = o_valid`.
  - Each pop captures `ofifo_dout`, `addr_cnt`, `first = (pass_cnt==0)` and `last = (pass_cnt==kij_len-1)` into pipeline register S1.
  - `addr_cnt` increments per pop and wraps num_inp-1 → 0. On that wrap `pass_cnt` increments.
  - The pop at addr num_inp-1 of pass kij_len-1 moves the FSM to DRAIN.
- DRAIN: `ofifo_rd = 0`. After one cycle (S1 commit), go to DONE.
- DONE: `compute_done = 1`. Host reads are allowed.
- `start` while `busy` is ignored.

**S1 commit (the cycle after a pop)**
- Per lane: `sum = first ? d : store[a] + d`, truncated to psum_bw bits. No saturation; overflow wraps.
- If `last` and latched `relu`: `sum = (sum < 0) ? 0 : sum`, per lane independently.
- `store[a] <= sum`.
- `iter_done` pulses in the cycle after the commit of a=num_inp-1, once per pass.

**Hazards and store behaviour**
- The read for the accumulate is combinational from the store.
- Consecutive pops always target different addresses (num_inp ≥ 2), so no forwarding is required.
- Store contents are not reset. Pass 0 overwrites every entry.

**Host read**
- In IDLE or DONE, `psum_rd=1` loads `psum_mem_dout <= store[psum_addr]`.
- Otherwise `psum_mem_dout` holds its value.
- `psum_rd` in RUN or DRAIN is ignored.

## Timing

**Reset values (asynchronous, while `reset`=0)**
- FSM is IDLE.
- `addr_cnt`, `pass_cnt` and S1 valid are 0.
- `ofifo_rd`, `iter_done`, `compute_done` and `busy` are 0.
- `psum_mem_dout` is 0.

**Latency and throughput**
- Pop cycle N → store written at the clock edge ending cycle N+1.
- `iter_done` is high in cycle N+2.
- Throughput is one vector per cycle when `o_valid` is held high.
- `o_valid` gaps stall the counters only; no bubbles are inserted into the address sequence.

**Overall schedule**
- Final pop in cycle F → DRAIN in F+1 → DONE and `compute_done`=1 in F+2.
- The last `iter_done` is also in F+2.

**Host read timing**
- `psum_rd` asserted in cycle R → data on `psum_mem_dout` in cycle R+1.
- Back-to-back reads sustain one per cycle.

**Boundary cases**
- Reset mid-RUN: any pending S1 write is dropped, and already-written entries keep their values.
- `start` coincident with `psum_rd` in DONE: the start wins, and the read in that cycle is ignored.
- kij_len=1: the single pass is both first and last, so ReLU applies to the raw data.

## Test plan

1. **Single pass** (kij_len=1, relu=0)
   - Stimulus: vector i lane k = i*8+k, with `o_valid` held high.
   - Required: the store equals the input, `iter_done` pulses once, and `compute_done` rises exactly 2 cycles after the 64th pop.
   - Required: reading addresses 0..63 returns the data 1 cycle after each `psum_rd`.
2. **Accumulation** (kij_len=3)
   - Stimulus: each pass feeds lane value (pass+1)*(i+1).
   - Required: entry i of every lane = 6*(i+1), and `iter_done` pulses 3 times, 64 pops apart.
3. **ReLU**
   - Stimulus: kij_len=2, relu=1, pass 0 = -5, pass 1 = +3 on lanes 0-3 and +7 on lanes 4-7.
   - Required: lanes 0-3 read 0, lanes 4-7 read 2.
   - Rerun with relu=0: lanes 0-3 read -2.
4. **Overflow and bubbles**
   - Stimulus: lane 0 gets 32767 then 1 over two passes, with `o_valid` toggling every other cycle.
   - Required: result -32768.
   - Required: `ofifo_rd` is never high while `o_valid`=0, and exactly 128 pops occur.
5. **Reset mid-pass**
   - Stimulus: drive `reset` low after 20 pops.
   - Required: all outputs are 0 in the same cycle and the FSM is IDLE.
   - Required: a following start/run completes normally with correct sums.
6. **Ignored requests**
   - Stimulus: assert `start` and `psum_rd` during RUN.
   - Required: the pass count is unaffected and `psum_mem_dout` is unchanged until DONE.

Source files
------------

// File: rtl/psum_accum_if.sv
// rtl/psum_accum_if.sv - output-FIFO drain and host read port bundle for psum_accum
interface psum_accum_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 6
);
  logic                   o_valid;
  logic [col*psum_bw-1:0] ofifo_dout;
  logic                   ofifo_rd;
  logic                   psum_rd;
  logic [addr_bw-1:0]     psum_addr;
  logic [col*psum_bw-1:0] psum_mem_dout;

  modport master (
    output o_valid, ofifo_dout, psum_rd, psum_addr,
    input  ofifo_rd, psum_mem_dout
  );

  modport slave (
    input  o_valid, ofifo_dout, psum_rd, psum_addr,
    output ofifo_rd, psum_mem_dout
  );
endinterface

// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - drains partial-sum vectors, accumulates them over kij_len passes,
// applies optional ReLU on the final pass and serves the store to the host.
module psum_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int num_inp = 64,
  parameter int kij_len = 9,
  parameter int addr_bw = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         relu,
  psum_accum_if.slave  bus,
  output logic         iter_done,
  output logic         compute_done,
  output logic         busy
);
  localparam int vec_bw  = col * psum_bw;
  localparam int pass_bw = $clog2(kij_len + 1);
  localparam logic [addr_bw-1:0] last_addr = addr_bw'(num_inp - 1);
  localparam logic [pass_bw-1:0] last_pass = pass_bw'(kij_len - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [addr_bw-1:0]  addr_cnt;
  logic [pass_bw-1:0]  pass_cnt;
  logic                relu_q;
  logic                s1_valid;
  logic                s1_first;
  logic                s1_last;
  logic [addr_bw-1:0]  s1_addr;
  logic [vec_bw-1:0]   s1_data;
  logic [vec_bw-1:0]   store [num_inp];
  logic [vec_bw-1:0]   prev;
  logic [vec_bw-1:0]   sum;
  logic                pop;
  logic                host_idle;

  assign pop          = (state == RUN) && bus.o_valid;
  assign bus.ofifo_rd = pop;
  assign host_idle    = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      pass_cnt     <= '0;
      relu_q       <= 1'b0;
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_addr      <= '0;
      s1_data      <= '0;
      iter_done    <= 1'b0;
      compute_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      s1_valid  <= pop;
      iter_done <= s1_valid && (s1_addr == last_addr);
      if (pop) begin
        s1_data  <= bus.ofifo_dout;
        s1_addr  <= addr_cnt;
        s1_first <= (pass_cnt == '0);
        s1_last  <= (pass_cnt == last_pass);
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            compute_done <= 1'b0;
            addr_cnt     <= '0;
            pass_cnt     <= '0;
            relu_q       <= relu;
          end
        end
        RUN: begin
          if (pop) begin
            if (addr_cnt == last_addr) begin
              addr_cnt <= '0;
              pass_cnt <= pass_cnt + 1'b1;
              if (pass_cnt == last_pass) state <= DRAIN;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // the final vector commits at the end of this cycle
          state        <= DONE;
          busy         <= 1'b0;
          compute_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Back-to-back pops never share an address, so the combinational read is always current.
  assign prev = store[s1_addr];

  for (genvar k = 0; k < col; k++) begin : g_lane
    logic signed [psum_bw-1:0] d;
    logic signed [psum_bw-1:0] acc;
    assign d   = s1_data[k*psum_bw +: psum_bw];
    assign acc = s1_first ? d : d + prev[k*psum_bw +: psum_bw];
    assign sum[k*psum_bw +: psum_bw] = (s1_last && relu_q && acc[psum_bw-1]) ? '0 : acc;
  end

  always_ff @(posedge clk) begin
    if (s1_valid) store[s1_addr] <= sum;
  end

  // a start in the same cycle takes priority over a host read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.psum_mem_dout <= '0;
    end else if (bus.psum_rd && host_idle && !start) begin
      bus.psum_mem_dout <= store[bus.psum_addr];
    end
  end
endmodule

// File: tb/tb_psum_accum.sv
// tb/tb_psum_accum.sv - self-checking bench for psum_accum, one instance per kij_len of 1, 2 and 3.
module tb_psum_accum;
  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n, start, relu, o_valid, psum_rd;
  logic [127:0] dout;
  logic [5:0]   psum_addr;
  int           sel;
  logic [2:0]   rd_v, it_v, cd_v, busy_v;
  logic [127:0] md_v [3];
  logic         ofifo_rd, it, cd, bsy;
  logic [127:0] md;

  psum_accum_if #(.col(8), .psum_bw(16), .addr_bw(6)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].o_valid    = o_valid && (sel == g);
    assign bus[g].ofifo_dout = dout;
    assign bus[g].psum_rd    = psum_rd && (sel == g);
    assign bus[g].psum_addr  = psum_addr;
    assign rd_v[g]           = bus[g].ofifo_rd;
    assign md_v[g]           = bus[g].psum_mem_dout;
    psum_accum #(.col(8), .psum_bw(16), .num_inp(N), .kij_len(g + 1), .addr_bw(6)) u_dut (
      .clk(clk), .reset(rst_n), .start(start && (sel == g)), .relu(relu), .bus(bus[g]),
      .iter_done(it_v[g]), .compute_done(cd_v[g]), .busy(busy_v[g])
    );
  end

  assign ofifo_rd = rd_v[sel[1:0]];
  assign it       = it_v[sel[1:0]];
  assign cd       = cd_v[sel[1:0]];
  assign bsy      = busy_v[sel[1:0]];
  assign md       = md_v[sel[1:0]];

  int           tests = 0, fails = 0;
  int           feed [3][N][8];
  logic [127:0] expw [N];
  logic [127:0] mstore [3][N];
  logic [127:0] held [3];

  typedef struct {
    bit rl;
    int vm;
    int a0, a1, b0, b1;
    int ea, eb;
  } rec_t;
  rec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input int p, input int i);
    logic [127:0] v;
    int x;
    for (int k = 0; k < 8; k++) begin
      x = feed[p][i][k];
      v[k*16 +: 16] = x[15:0];
    end
    return v;
  endfunction

  // expected store: plain integer sum over passes, wrapped to 16 bits, then ReLU
  task automatic model(input int s, input bit rl);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 8; k++) begin
        int tot;
        logic [15:0] t;
        tot = 0;
        for (int p = 0; p <= s; p++) tot += feed[p][i][k];
        t = tot[15:0];
        if (rl && t[15]) t = '0;
        expw[i][k*16 +: 16] = t;
      end
    end
  endtask

  task automatic fill_random(input int s);
    for (int p = 0; p <= s; p++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 8; k++)
          feed[p][i][k] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // vm: 0 = o_valid held high, 1 = toggling, 2 = random; stop_at > 0 halts after that many pops
  task automatic run(input int s, input bit rl, input int vm, input int stop_at, input bit poke);
    int total, idx, g, pops, bad, holdbad, last_pop, done_c;
    int iq [$];
    bit poked;
    total = (s + 1) * N;
    idx = 0; g = 0; pops = 0; bad = 0; holdbad = 0; last_pop = -1; done_c = -1; poked = 0;
    sel = s;
    @(posedge clk); #1;
    start = 1'b1; relu = rl;
    if (poke) begin psum_rd = 1'b1; psum_addr = 6'd9; end
    @(posedge clk); #1;
    start = 1'b0; relu = ~rl; psum_rd = 1'b0;
    if (poke) begin
      chk("start_wins_busy", bsy, 1);
      chk("start_wins_hold", md, held[s]);
    end
    while (idx < total && !(stop_at > 0 && idx >= stop_at) && g < 4 * total + 20) begin
      o_valid = (vm == 0) ? 1'b1 : (vm == 1) ? (g[0] == 1'b0) : 1'($urandom_range(0, 1));
      dout = pack(idx / N, idx % N);
      if (poke && idx == 30 && !poked) begin
        start = 1'b1; psum_rd = 1'b1; psum_addr = 6'd3; poked = 1;
      end else begin
        start = 1'b0; psum_rd = 1'b0;
      end
      @(negedge clk);
      if (ofifo_rd && !o_valid) bad++;
      if (ofifo_rd) begin pops++; last_pop = cyc; idx++; end
      if (it) iq.push_back(cyc);
      if (poke && md !== held[s]) holdbad++;
      @(posedge clk); #1;
      g++;
    end
    start = 1'b0; psum_rd = 1'b0;
    if (stop_at > 0 && idx >= stop_at) return;
    o_valid = 1'b0;
    if (idx < total) chk("pop_timeout", idx, total);
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (ofifo_rd) begin pops++; bad++; end
      if (it) iq.push_back(cyc);
      if (cd && done_c < 0) done_c = cyc;
      if (poke && !cd && md !== held[s]) holdbad++;
    end
    chk($sformatf("pops_k%0d", s + 1), pops, total);
    chk("rd_without_valid", bad, 0);
    chk("done_latency", done_c - last_pop, 2);
    chk("iter_count", iq.size(), s + 1);
    if (iq.size() > 0) chk("last_iter_latency", iq[iq.size() - 1] - last_pop, 2);
    if (vm == 0)
      for (int i = 1; i < iq.size(); i++) chk("iter_spacing", iq[i] - iq[i - 1], N);
    chk("busy_end", bsy, 0);
    chk("done_level", cd, 1);
    if (poke) chk("hold_in_run", holdbad, 0);
  endtask

  task automatic read_all(input int s);
    sel = s;
    for (int a = 0; a <= N; a++) begin
      @(posedge clk); #1;
      if (a < N) begin psum_rd = 1'b1; psum_addr = a[5:0]; end
      else psum_rd = 1'b0;
      if (a > 0) begin
        @(negedge clk);
        chk($sformatf("read_k%0d[%0d]", s + 1, a - 1), md, expw[a - 1]);
      end
    end
    for (int i = 0; i < N; i++) mstore[s][i] = expw[i];
    held[s] = expw[N - 1];
  endtask

  initial begin
    tbl[0] = '{rl: 1, vm: 0, a0: -5,     a1: 3,  b0: -5,    b1: 7,     ea: 0,      eb: 2};
    tbl[1] = '{rl: 0, vm: 0, a0: -5,     a1: 3,  b0: -5,    b1: 7,     ea: -2,     eb: 2};
    tbl[2] = '{rl: 0, vm: 1, a0: 32767,  a1: 1,  b0: 100,   b1: -300,  ea: -32768, eb: -200};
    tbl[3] = '{rl: 1, vm: 1, a0: 32767,  a1: 1,  b0: -1,    b1: -1,    ea: 0,      eb: 0};
    tbl[4] = '{rl: 0, vm: 0, a0: -32768, a1: -1, b0: 20000, b1: 20000, ea: 32767,  eb: -25536};

    rst_n = 1'b0; start = 1'b0; relu = 1'b0; o_valid = 1'b0; psum_rd = 1'b0;
    psum_addr = '0; dout = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_ofifo_rd", rd_v[g], 0);
      chk("rst_iter_done", it_v[g], 0);
      chk("rst_compute_done", cd_v[g], 0);
      chk("rst_busy", busy_v[g], 0);
      chk("rst_mem_dout", md_v[g], 0);
    end
    rst_n = 1'b1;

    // single pass, data = i*8+k
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) feed[0][i][k] = i * 8 + k;
    model(0, 0);
    run(0, 0, 0, 0, 0);
    read_all(0);

    // three-pass accumulation: entry i = 6*(i+1)
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 8; k++) feed[p][i][k] = (p + 1) * (i + 1);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) expw[i][k*16 +: 16] = 16'(6 * (i + 1));
    run(2, 0, 0, 0, 0);
    read_all(2);

    // ReLU, wraparound and bubble vectors on the two-pass instance
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < 8; k++) begin
          feed[0][i][k] = (k < 4) ? tbl[r].a0 : tbl[r].b0;
          feed[1][i][k] = (k < 4) ? tbl[r].a1 : tbl[r].b1;
          expw[i][k*16 +: 16] = (k < 4) ? 16'(tbl[r].ea) : 16'(tbl[r].eb);
        end
      end
      run(1, tbl[r].rl, tbl[r].vm, 0, 0);
      read_all(1);
    end

    // randomized runs against the arithmetic model
    for (int s = 0; s < 2; s++) begin
      bit rl;
      rl = 1'($urandom_range(0, 1));
      if (s == 0) rl = 1'b1;
      fill_random(s);
      model(s, rl);
      run(s, rl, 2, 0, 0);
      read_all(s);
    end

    // start+read in DONE, then start and read requests while busy
    fill_random(1);
    model(1, 1);
    run(1, 1, 0, 0, 1);
    read_all(1);

    // reset after 20 pops: the 20th vector's write is dropped
    fill_random(2);
    run(2, 0, 0, 20, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ofifo_rd", ofifo_rd, 0);
    chk("midrst_busy", bsy, 0);
    chk("midrst_iter_done", it, 0);
    chk("midrst_compute_done", cd, 0);
    chk("midrst_mem_dout", md, 0);
    o_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) held[g] = '0;
    for (int i = 0; i < N; i++) expw[i] = (i < 19) ? pack(0, i) : mstore[2][i];
    read_all(2);
    fill_random(2);
    model(2, 1);
    run(2, 1, 2, 0, 0);
    read_all(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
